// File: rtl/ahb_pkg.sv
`default_nettype none
// ahb_pkg: shared AHB transfer, response and FSM encodings for the SRAM subordinate.
// Rev 1.0
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef logic [2:0] size_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// ahb_sram_array: word-organised SRAM, combinational read, byte-strobed registered write.
// Rev 1.0
module ahb_sram_array #(
  parameter int DataWidth = 32,
  parameter int WordAw    = 10
) (
  input  logic                   clk,
  input  logic [WordAw-1:0]      word_addr,
  input  logic                   wr_en,
  input  logic [DataWidth/8-1:0] strb,
  input  logic [DataWidth-1:0]   wr_data,
  output logic [DataWidth-1:0]   rd_data
);

  localparam int Bytes = DataWidth / 8;

  logic [DataWidth-1:0] mem [2**WordAw];

  assign rd_data = mem[word_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < Bytes; i++) begin
        if (strb[i]) mem[word_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_sub.sv
`default_nettype none
// ahb_sram_sub: AHB subordinate serving an internal SRAM with wait states and two-cycle ERROR.
// Rev 1.0
module ahb_sram_sub
  import ahb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int MemBytes   = 4096,
  parameter int WaitStates = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [2:0]           burst,
  input  logic [3:0]           prot,
  input  logic [1:0]           trans,
  input  logic                 mastLock,
  input  logic                 ready,
  input  logic [DataWidth-1:0] wData,
  output logic                 readyOut,
  output logic                 resp,
  output logic [DataWidth-1:0] rData
);

  localparam int Bytes     = DataWidth / 8;
  localparam int ByteShift = $clog2(Bytes);
  localparam int MemAw     = $clog2(MemBytes);
  localparam int WordAw    = MemAw - ByteShift;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [MemAw-1:0] dp_addr;
  logic             dp_write;
  size_t            dp_size;

  logic                 accept;
  logic                 bad;
  logic [63:0]          addr_ext;
  logic [63:0]          size_bytes;
  logic [Bytes-1:0]     strb;
  logic [DataWidth-1:0] rd_word;
  logic                 wr_en;
  int                   lane_off;
  int                   lane_cnt;
  logic                 unused_inputs;

  assign unused_inputs = ^{burst, prot, mastLock};

  // SEQ and NONSEQ are handled identically; BUSY/IDLE never start a data phase.
  assign accept = sel && ready && readyOut && (trans == TRANS_NONSEQ || trans == TRANS_SEQ);

  assign addr_ext   = 64'(addr);
  assign size_bytes = 64'd1 << size;
  assign bad = (size_bytes > 64'(Bytes))
            || ((addr_ext & (size_bytes - 64'd1)) != 64'd0)
            || (addr_ext >= 64'(MemBytes));

  always_comb begin
    lane_off = int'(dp_addr) % Bytes;
    lane_cnt = 1 << dp_size;
    strb     = '0;
    for (int i = 0; i < Bytes; i++) begin
      strb[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
    end
  end

  assign wr_en = (state == ST_XFER) && dp_write && !reset;
  assign rData = (state == ST_XFER) ? rd_word : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      readyOut <= 1'b1;
      resp     <= RESP_OKAY;
      wait_cnt <= 4'd0;
      dp_addr  <= '0;
      dp_write <= 1'b0;
      dp_size  <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state    <= ST_XFER;
            readyOut <= 1'b1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          readyOut <= 1'b1;
          resp     <= RESP_ERROR;
        end
        default: begin
          // IDLE, XFER and ERR2 all end with readyOut high and may take a new transfer.
          if (accept) begin
            dp_addr  <= addr[MemAw-1:0];
            dp_write <= write;
            dp_size  <= size;
            if (bad) begin
              state    <= ST_ERR1;
              readyOut <= 1'b0;
              resp     <= RESP_ERROR;
            end else if (WaitStates > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WaitStates);
              readyOut <= 1'b0;
              resp     <= RESP_OKAY;
            end else begin
              state    <= ST_XFER;
              readyOut <= 1'b1;
              resp     <= RESP_OKAY;
            end
          end else begin
            state    <= ST_IDLE;
            readyOut <= 1'b1;
            resp     <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  ahb_sram_array #(
    .DataWidth(DataWidth),
    .WordAw   (WordAw)
  ) u_array (
    .clk      (clk),
    .word_addr(dp_addr[MemAw-1:ByteShift]),
    .wr_en    (wr_en),
    .strb     (strb),
    .wr_data  (wData),
    .rd_data  (rd_word)
  );

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_sub.sv
`default_nettype none
// tb_ahb_sram_sub: table vectors, corner sequences and a random run against a byte-array model.
// Rev 1.0
module tb_ahb_sram_sub;
  import ahb_pkg::*;

  localparam logic [1:0] NS  = 2'd2;
  localparam logic [1:0] SQ  = 2'd3;
  localparam logic [1:0] BSY = 2'd1;
  localparam logic [1:0] IDL = 2'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3, sel, write, lock;
  logic [31:0] addr, wdata;
  logic [2:0]  size, burst;
  logic [3:0]  prot;
  logic [1:0]  trans;
  int          tgt;
  logic        ro0, ro3, rsp0, rsp3, sel0, sel3;
  logic [31:0] rd0, rd3;
  logic        ready_m, resp_m;
  logic [31:0] rdata_m;

  assign sel0    = sel && (tgt == 0);
  assign sel3    = sel && (tgt == 1);
  assign ready_m = (tgt == 0) ? ro0 : ro3;
  assign resp_m  = (tgt == 0) ? rsp0 : rsp3;
  assign rdata_m = (tgt == 0) ? rd0 : rd3;

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .MemBytes(4096), .WaitStates(0)) u_dut0 (
    .clk(clk), .reset(rst0), .sel(sel0), .addr(addr), .write(write), .size(size),
    .burst(burst), .prot(prot), .trans(trans), .mastLock(lock), .ready(ro0),
    .wData(wdata), .readyOut(ro0), .resp(rsp0), .rData(rd0));

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .MemBytes(4096), .WaitStates(3)) u_dut3 (
    .clk(clk), .reset(rst3), .sel(sel3), .addr(addr), .write(write), .size(size),
    .burst(burst), .prot(prot), .trans(trans), .mastLock(lock), .ready(ro3),
    .wData(wdata), .readyOut(ro3), .resp(rsp3), .rData(rd3));

  int checks = 0;
  int errors = 0;
  logic [7:0] mm [0:4095];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // One isolated transfer: address phase, then data phase until ready (bounded).
  task automatic xfer(input int t, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [1:0] tr, input logic [31:0] wd,
                      output int lows, output logic r_first, output logic r_final,
                      output logic [31:0] rd);
    @(posedge clk); #1;
    tgt = t; sel = 1'b1; addr = a; write = w; size = sz; trans = tr;
    @(posedge clk); #1;
    sel = 1'b0; trans = IDL; wdata = wd;
    lows = 0;
    @(negedge clk);
    r_first = resp_m;
    while (!ready_m && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    r_final = resp_m;
    rd = rdata_m;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [2:0]  sz;
    logic [1:0]  tr;
    logic [31:0] wd;
    int          lows;
    logic        rsp;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(logic [31:0] a, logic w, logic [2:0] sz, logic [1:0] tr,
                              logic [31:0] wd, int lows, logic rsp, logic chk_rd, logic [31:0] rd);
    vec_t v;
    v.a = a; v.w = w; v.sz = sz; v.tr = tr; v.wd = wd;
    v.lows = lows; v.rsp = rsp; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  function automatic logic [31:0] mword(int a);
    int wa;
    wa = a - (a % 4);
    return {mm[wa+3], mm[wa+2], mm[wa+1], mm[wa]};
  endfunction

  vec_t tbl[$];

  initial begin
    int          lows;
    logic        r1, r2;
    logic [31:0] rd;

    rst0 = 1'b1; rst3 = 1'b1; sel = 1'b0; write = 1'b0; lock = 1'b0;
    addr = '0; wdata = '0; size = 3'd2; burst = 3'd1; prot = 4'h3; trans = IDL; tgt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready0", {31'd0, ro0}, 32'd1);
    check("reset_resp0", {31'd0, rsp0}, 32'd0);
    check("reset_rdata0", rd0, 32'd0);
    check("reset_ready3", {31'd0, ro3}, 32'd1);
    check("reset_resp3", {31'd0, rsp3}, 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst3 = 1'b0;

    // Expected values are hand-derived from the transfer rules.
    tbl.push_back(mk(32'h10,   1, 3'd2, NS,  32'hDEADBEEF, 0, 0, 0, 32'h0));
    tbl.push_back(mk(32'h10,   0, 3'd2, NS,  32'h0,        0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(32'h13,   1, 3'd0, NS,  32'hAA000000, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(32'h10,   0, 3'd2, NS,  32'h0,        0, 0, 1, 32'hAAADBEEF));
    tbl.push_back(mk(32'h02,   0, 3'd2, NS,  32'h0,        1, 1, 1, 32'h0));
    tbl.push_back(mk(32'h12,   1, 3'd2, NS,  32'h11223344, 1, 1, 1, 32'h0));
    tbl.push_back(mk(32'h10,   0, 3'd2, NS,  32'h0,        0, 0, 1, 32'hAAADBEEF));
    tbl.push_back(mk(32'h00,   1, 3'd2, NS,  32'h01234567, 0, 0, 0, 32'h0));
    tbl.push_back(mk(32'h1000, 1, 3'd2, NS,  32'hFFFFFFFF, 1, 1, 1, 32'h0));
    tbl.push_back(mk(32'h00,   0, 3'd2, SQ,  32'h0,        0, 0, 1, 32'h01234567));
    tbl.push_back(mk(32'h00,   0, 3'd3, NS,  32'h0,        1, 1, 1, 32'h0));
    tbl.push_back(mk(32'h14,   1, 3'd2, NS,  32'h55667788, 0, 0, 0, 32'h0));
    tbl.push_back(mk(32'h16,   1, 3'd1, NS,  32'hBEEF0000, 0, 0, 1, 32'h55667788));
    tbl.push_back(mk(32'h14,   0, 3'd2, NS,  32'h0,        0, 0, 1, 32'hBEEF7788));
    tbl.push_back(mk(32'h15,   0, 3'd1, NS,  32'h0,        1, 1, 1, 32'h0));
    tbl.push_back(mk(32'h11,   0, 3'd0, NS,  32'h0,        0, 0, 1, 32'hAAADBEEF));
    tbl.push_back(mk(32'hFFC,  1, 3'd2, NS,  32'hCAFEF00D, 0, 0, 0, 32'h0));
    tbl.push_back(mk(32'hFFC,  0, 3'd2, NS,  32'h0,        0, 0, 1, 32'hCAFEF00D));
    tbl.push_back(mk(32'hFFE,  0, 3'd1, NS,  32'h0,        0, 0, 1, 32'hCAFEF00D));
    tbl.push_back(mk(32'h02,   0, 3'd2, BSY, 32'h0,        0, 0, 1, 32'h0));
    tbl.push_back(mk(32'h1000, 1, 3'd2, IDL, 32'h0,        0, 0, 1, 32'h0));

    foreach (tbl[i]) begin
      xfer(0, tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].tr, tbl[i].wd, lows, r1, r2, rd);
      check($sformatf("tbl%0d_lows", i), 32'(lows), 32'(tbl[i].lows));
      check($sformatf("tbl%0d_resp1", i), {31'd0, r1}, {31'd0, tbl[i].rsp});
      check($sformatf("tbl%0d_resp2", i), {31'd0, r2}, {31'd0, tbl[i].rsp});
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
    end

    // Back-to-back write then read of the same word.
    @(posedge clk); #1;
    tgt = 0; sel = 1'b1; addr = 32'h20; write = 1'b1; size = 3'd2; trans = NS;
    @(posedge clk); #1;
    wdata = 32'h13579BDF; write = 1'b0; trans = NS;
    @(posedge clk); #1;
    sel = 1'b0; trans = IDL;
    @(negedge clk);
    check("b2b_rdata", rd0, 32'h13579BDF);
    check("b2b_ready", {31'd0, ro0}, 32'd1);
    check("b2b_resp", {31'd0, rsp0}, 32'd0);

    // Out-of-range write with a SEQ read held through the ERROR pair.
    @(posedge clk); #1;
    tgt = 0; sel = 1'b1; addr = 32'h1000; write = 1'b1; size = 3'd2; trans = NS;
    @(posedge clk); #1;
    addr = 32'h0; write = 1'b0; trans = SQ; wdata = 32'h0;
    @(negedge clk);
    check("err1_ready", {31'd0, ro0}, 32'd0);
    check("err1_resp", {31'd0, rsp0}, 32'd1);
    @(negedge clk);
    check("err2_ready", {31'd0, ro0}, 32'd1);
    check("err2_resp", {31'd0, rsp0}, 32'd1);
    @(posedge clk); #1;
    sel = 1'b0; trans = IDL;
    @(negedge clk);
    check("after_err_ready", {31'd0, ro0}, 32'd1);
    check("after_err_resp", {31'd0, rsp0}, 32'd0);
    check("after_err_rdata", rd0, 32'h01234567);

    // Three wait states.
    xfer(1, 32'h40, 1'b1, 3'd2, NS, 32'h0BADCAFE, lows, r1, r2, rd);
    check("ws3_wr_lows", 32'(lows), 32'd3);
    check("ws3_wr_resp", {31'd0, r1 | r2}, 32'd0);
    xfer(1, 32'h40, 1'b0, 3'd2, NS, 32'h0, lows, r1, r2, rd);
    check("ws3_rd_lows", 32'(lows), 32'd3);
    check("ws3_rd_resp", {31'd0, r1 | r2}, 32'd0);
    check("ws3_rd_rdata", rd, 32'h0BADCAFE);
    @(negedge clk);
    check("ws3_rd_after", rd3, 32'h0);

    // Reset during WAIT of a write abandons it.
    @(posedge clk); #1;
    tgt = 1; sel = 1'b1; addr = 32'h40; write = 1'b1; size = 3'd2; trans = NS;
    @(posedge clk); #1;
    sel = 1'b0; trans = IDL; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rstwait_ready_low", {31'd0, ro3}, 32'd0);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    check("rstwait_ready", {31'd0, ro3}, 32'd1);
    check("rstwait_resp", {31'd0, rsp3}, 32'd0);
    check("rstwait_rdata", rd3, 32'h0);
    xfer(1, 32'h40, 1'b0, 3'd2, NS, 32'h0, lows, r1, r2, rd);
    check("rstwait_word", rd, 32'h0BADCAFE);

    // Random run against the byte model over a small region plus out-of-range addresses.
    for (int wi = 0; wi < 16; wi++) begin
      logic [31:0] v;
      v = $urandom;
      xfer(0, 32'(wi * 4), 1'b1, 3'd2, NS, v, lows, r1, r2, rd);
      for (int b = 0; b < 4; b++) mm[wi*4 + b] = v[b*8 +: 8];
    end
    for (int n = 0; n < 150; n++) begin
      int          a, nb, el;
      logic        w, ebad;
      logic [2:0]  sz;
      logic [1:0]  tr;
      logic [31:0] wd, er;
      a    = ($urandom_range(0, 9) == 0) ? 4096 + int'($urandom_range(0, 1023))
                                         : int'($urandom_range(0, 63));
      w    = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 3));
      tr   = ($urandom_range(0, 1) == 0) ? NS : SQ;
      wd   = $urandom;
      nb   = 1 << sz;
      ebad = (nb > 4) || (a % nb != 0) || (a >= 4096);
      el   = ebad ? 1 : 0;
      er   = ebad ? 32'h0 : mword(a);
      xfer(0, 32'(a), w, sz, tr, wd, lows, r1, r2, rd);
      check($sformatf("rnd%0d_lows", n), 32'(lows), 32'(el));
      check($sformatf("rnd%0d_resp", n), {30'd0, r1, r2}, {30'd0, ebad, ebad});
      check($sformatf("rnd%0d_rdata", n), rd, er);
      if (!ebad && w) begin
        for (int b = 0; b < nb; b++) mm[a + b] = wd[((a % 4) + b)*8 +: 8];
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
